// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the producers and the RF write-port arbiter.
// The master side drives requests and stall; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned GID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      wb_stall;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [GID_W-1:0]          grant_id;
  logic [CNT_W-1:0]          acc_cnt;

  modport master (
    output src_valid, src_addr, src_data, wb_stall,
    input  src_ready, rf_we, rf_waddr, rf_wdata, grant_id, acc_cnt
  );

  modport slave (
    input  src_valid, src_addr, src_data, wb_stall,
    output src_ready, rf_we, rf_waddr, rf_wdata, grant_id, acc_cnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter of register-file writebacks onto one registered RF write port.
// Define RF_WB_FIXED_PRIO_EN for fixed priority (source 0 highest, no rotating pointer).
module rf_wb_arbiter #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int unsigned GID_W = $clog2(NUM_SRC);

  logic [GID_W-1:0]  start_ptr;
  logic [GID_W-1:0]  cand;
  logic [GID_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;

  function automatic logic [GID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return GID_W'(s);
  endfunction

`ifdef RF_WB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;

  assign start_ptr = rr_ptr_q;
  assign rr_ptr_d  = hs ? wrap_idx(int'(gnt_idx), 1) : rr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // First valid source at or after start_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = wrap_idx(int'(start_ptr), i);
      if (!gnt_any && bus.src_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // rst only gates the visible ready; the flops are held in reset anyway.
  assign hs       = gnt_any && !bus.wb_stall;
  assign sel_addr = bus.src_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = bus.src_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    bus.src_ready = '0;
    if (hs && !rst) bus.src_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rf_we_d    = hs && (sel_addr != '0);
    rf_waddr_d = hs ? sel_addr : rf_waddr_q;
    rf_wdata_d = hs ? sel_data : rf_wdata_q;
    grant_id_d = hs ? gnt_idx : grant_id_q;
    acc_cnt_d  = acc_cnt_q;
    if (rf_we_d && (acc_cnt_q != {CNT_W{1'b1}})) acc_cnt_d = acc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      acc_cnt_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.grant_id = grant_id_q;
  assign bus.acc_cnt  = acc_cnt_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (round-robin build, CNT_W=4 to reach saturation).
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  rf_wb_arbiter_if #(.NUM_SRC(3), .ADDR_W(5), .DATA_W(32), .CNT_W(4)) bus ();

  rf_wb_arbiter #(.NUM_SRC(3), .ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.src_addr[i*5 +: 5]   = a;
    bus.src_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.src_valid = 3'b111;
    bus.src_addr  = '0;
    bus.src_data  = '0;
    bus.wb_stall  = 1'b0;
    #2;
    chk("rst_we", 64'(bus.rf_we), 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_gid", 64'(bus.grant_id), 64'd0);
    chk("rst_acc", 64'(bus.acc_cnt), 64'd0);
    chk("rst_ready", 64'(bus.src_ready), 64'd0);

    // Single source
    @(negedge clk);
    rst = 1'b0;
    set_src(1, 5'd5, 32'hDEADBEEF);
    bus.src_valid = 3'b010;
    #1 chk("single_ready", 64'(bus.src_ready), 64'b010);
    @(posedge clk); #1;
    chk("single_we", 64'(bus.rf_we), 64'd1);
    chk("single_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("single_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    chk("single_gid", 64'(bus.grant_id), 64'd1);
    chk("single_acc", 64'(bus.acc_cnt), 64'd1);
    bus.src_valid = 3'b000;
    @(posedge clk); #1;
    chk("idle_we", 64'(bus.rf_we), 64'd0);
    chk("idle_waddr_hold", 64'(bus.rf_waddr), 64'd5);
    chk("idle_gid_hold", 64'(bus.grant_id), 64'd1);

    // All sources valid from reset release: 0,1,2,0,1,2
    do_reset();
    set_src(0, 5'd1, 32'hA0);
    set_src(1, 5'd2, 32'hA1);
    set_src(2, 5'd3, 32'hA2);
    bus.src_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 64'(bus.src_ready), 64'(1 << (k % 3)));
      @(posedge clk); #1;
      chk("rr_we", 64'(bus.rf_we), 64'd1);
      chk("rr_gid", 64'(bus.grant_id), 64'(k % 3));
      chk("rr_waddr", 64'(bus.rf_waddr), 64'((k % 3) + 1));
    end
    bus.src_valid = 3'b000;
    chk("rr_acc", 64'(bus.acc_cnt), 64'd6);
    @(posedge clk); #1;
    chk("rr_idle_we", 64'(bus.rf_we), 64'd0);

    // x0 write from source 2, then sources 0 and 2 (rr_ptr back at 0)
    set_src(2, 5'd0, 32'h1234);
    bus.src_valid = 3'b100;
    #1 chk("x0_ready", 64'(bus.src_ready), 64'b100);
    @(posedge clk); #1;
    chk("x0_we", 64'(bus.rf_we), 64'd0);
    chk("x0_gid", 64'(bus.grant_id), 64'd2);
    chk("x0_wdata", 64'(bus.rf_wdata), 64'h1234);
    chk("x0_acc", 64'(bus.acc_cnt), 64'd6);
    bus.src_valid = 3'b101;
    #1 chk("x0_next_ready", 64'(bus.src_ready), 64'b001);
    @(posedge clk); #1;
    chk("x0_next_gid", 64'(bus.grant_id), 64'd0);
    chk("x0_next_acc", 64'(bus.acc_cnt), 64'd7);

    // Stall: prior write from source 2 drains, then 3 stalled cycles
    set_src(2, 5'd3, 32'hC2);
    bus.src_valid = 3'b100;
    #1 chk("pre_stall_ready", 64'(bus.src_ready), 64'b100);
    @(posedge clk); #1;
    chk("drain_we", 64'(bus.rf_we), 64'd1);
    chk("drain_waddr", 64'(bus.rf_waddr), 64'd3);
    chk("drain_acc", 64'(bus.acc_cnt), 64'd8);
    bus.src_valid = 3'b011;
    bus.wb_stall  = 1'b1;
    #1 chk("stall_ready", 64'(bus.src_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_we", 64'(bus.rf_we), 64'd0);
      chk("stall_ready_held", 64'(bus.src_ready), (k == 2) ? 64'd0 : 64'd0);
    end
    bus.wb_stall = 1'b0;
    #1 chk("unstall_ready", 64'(bus.src_ready), 64'b001);
    @(posedge clk); #1;
    chk("unstall_gid", 64'(bus.grant_id), 64'd0);
    chk("unstall_acc", 64'(bus.acc_cnt), 64'd9);
    bus.src_valid = 3'b010;
    #1 chk("unstall2_ready", 64'(bus.src_ready), 64'b010);
    @(posedge clk); #1;
    chk("unstall2_gid", 64'(bus.grant_id), 64'd1);
    chk("unstall2_we", 64'(bus.rf_we), 64'd1);
    bus.src_valid = 3'b000;

    // Async reset between edges while rf_we is high
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 64'(bus.rf_we), 64'd0);
    chk("arst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("arst_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("arst_acc", 64'(bus.acc_cnt), 64'd0);
    bus.src_valid = 3'b111;
    #1 chk("arst_ready", 64'(bus.src_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_rel_ready", 64'(bus.src_ready), 64'b001);
    @(posedge clk); #1;
    chk("arst_rel_gid", 64'(bus.grant_id), 64'd0);
    chk("arst_rel_acc", 64'(bus.acc_cnt), 64'd1);

    // Saturation: 20 more non-x0 writes from source 1
    set_src(1, 5'd7, 32'h77);
    bus.src_valid = 3'b010;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("sat_acc", 64'(bus.acc_cnt), (k + 2 > 15) ? 64'd15 : 64'(k + 2));
    end
    bus.src_valid = 3'b000;
    @(posedge clk); #1;
    chk("sat_idle_we", 64'(bus.rf_we), 64'd0);
    chk("sat_hold", 64'(bus.acc_cnt), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
